pipeline_pixel_merge: RTL

- Parametrised N-lane merge stage between replicated PipelineMath lanes and PipelineTail.
- Round-robin arbitrates N pixel streams (data + metadata) into one registered output stream.
- Enforces a per-frame barrier: a lane that has sent its end-of-frame beat is masked until every lane has done so. Exactly one end-of-frame marker then reaches the tail per frame.
- Replaces the fixed single-lane math-to-tail connection.

---
 rtl/pipeline_pixel_merge.sv | 106 ++++++++++
 1 files changed

// File: rtl/pipeline_pixel_merge.sv
// rtl/pipeline_pixel_merge.sv - round-robin N-lane pixel merge with per-frame end-of-frame barrier
module pipeline_pixel_merge #(
  parameter int NUM_LANES = 4,
  parameter int DATA_W    = 32,
  parameter int META_W    = 8,
  parameter int LAST_BIT  = 0
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic [NUM_LANES-1:0]          pixel_s_valid,
  output logic [NUM_LANES-1:0]          pixel_s_ready,
  input  logic [NUM_LANES*DATA_W-1:0]   pixel_s_data,
  input  logic [NUM_LANES*META_W-1:0]   pixel_s_metadata,
  output logic                          pixel_m_valid,
  input  logic                          pixel_m_ready,
  output logic [DATA_W-1:0]             pixel_m_data,
  output logic [META_W-1:0]             pixel_m_metadata,
  output logic [NUM_LANES-1:0]          lanes_done,
  output logic                          frame_done
);

  localparam int PTR_W = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
  localparam logic [PTR_W-1:0] LAST_LANE = PTR_W'(NUM_LANES - 1);
  localparam logic [NUM_LANES-1:0] ALL_DONE = '1;

  logic [PTR_W-1:0]     ptr;
  logic [PTR_W-1:0]     win;
  logic [PTR_W-1:0]     idx;
  logic                 found;
  logic                 load;
  logic                 grant;
  logic [NUM_LANES-1:0] eligible;
  logic [NUM_LANES-1:0] win_oh;
  logic [NUM_LANES-1:0] done_next;
  logic                 final_lane;
  logic                 sel_last;
  logic [DATA_W-1:0]    sel_data;
  logic [META_W-1:0]    sel_meta;
  logic [META_W-1:0]    fwd_meta;

  logic [DATA_W-1:0]    lane_data [NUM_LANES];
  logic [META_W-1:0]    lane_meta [NUM_LANES];

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    assign lane_data[g] = pixel_s_data[g*DATA_W +: DATA_W];
    assign lane_meta[g] = pixel_s_metadata[g*META_W +: META_W];
  end

  assign load     = !pixel_m_valid || pixel_m_ready;
  assign eligible = pixel_s_valid & ~lanes_done;

  // Scan from the pointer upward; the index wraps explicitly so odd lane counts work.
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = ptr;
    for (int k = 0; k < NUM_LANES; k++) begin
      if (!found && eligible[idx]) begin
        found = 1'b1;
        win   = idx;
      end
      idx = (idx == LAST_LANE) ? '0 : idx + PTR_W'(1);
    end
  end

  assign grant         = rstn && found && load;
  assign win_oh        = NUM_LANES'(1) << win;
  assign pixel_s_ready = grant ? win_oh : '0;

  assign sel_data   = lane_data[win];
  assign sel_meta   = lane_meta[win];
  assign sel_last   = sel_meta[LAST_BIT];
  assign done_next  = lanes_done | win_oh;
  assign final_lane = (done_next == ALL_DONE);

  // Only the lane that completes the barrier carries the end-of-frame marker downstream.
  always_comb begin
    fwd_meta           = sel_meta;
    fwd_meta[LAST_BIT] = sel_last && final_lane;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      pixel_m_valid    <= 1'b0;
      pixel_m_data     <= '0;
      pixel_m_metadata <= '0;
      lanes_done       <= '0;
      frame_done       <= 1'b0;
      ptr              <= '0;
    end else begin
      frame_done <= pixel_m_valid && pixel_m_ready && pixel_m_metadata[LAST_BIT];
      if (grant) begin
        pixel_m_valid    <= 1'b1;
        pixel_m_data     <= sel_data;
        pixel_m_metadata <= fwd_meta;
        ptr              <= (win == LAST_LANE) ? '0 : win + PTR_W'(1);
        if (sel_last) begin
          lanes_done <= final_lane ? '0 : done_next;
        end
      end else if (pixel_m_ready) begin
        pixel_m_valid <= 1'b0;
      end
    end
  end

endmodule
